// File: rtl/tetris_pkg.sv
// Shared Tetris constants: board geometry, screen and RAM widths, colour type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tetris_pkg;

  // Board geometry in cells.
  localparam int BOARD_W  = 10;
  localparam int BOARD_H  = 20;
  localparam int CELLS    = BOARD_W * BOARD_H;

  // VGA adapter screen geometry and coordinate widths.
  localparam int SCR_W    = 160;
  localparam int SCR_H    = 120;
  localparam int SCR_X_W  = 8;
  localparam int SCR_Y_W  = 7;

  // Board RAM word and address widths.
  localparam int COLOUR_W = 6;
  localparam int RAM_AW   = 8;

  typedef logic [COLOUR_W-1:0] colour_t;

endpackage

// File: rtl/cell_painter.sv
// Paints one CELL_PX x CELL_PX square: walks px/py and drives registered X/Y/colour/wren.
// Latency: first pixel appears the cycle after start; square takes CELL_PX*CELL_PX cycles.
// Backpressure: none; one pixel per cycle, last flags the final pixel of the square.
module cell_painter
  import tetris_pkg::*;
#(
  parameter int CELL_PX = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [8:0]         base_x,
  input  logic [8:0]         base_y,
  input  colour_t            cell_colour,
  output logic [SCR_X_W-1:0] x,
  output logic [SCR_Y_W-1:0] y,
  output colour_t            colour,
  output logic               wren,
  output logic               last
);

  localparam int            PW     = $clog2(CELL_PX + 1);
  localparam logic [PW-1:0] PX_MAX = PW'(CELL_PX - 1);

  // px/py name the pixel currently presented on x/y; wren doubles as "square active".
  logic [PW-1:0] px;
  logic [PW-1:0] py;
  logic [PW-1:0] px_nxt;
  logic [PW-1:0] py_nxt;

  assign last = wren && (px == PX_MAX) && (py == PX_MAX);

  // Raster step: px runs fastest, py advances when px wraps; start restarts at the corner.
  always_comb begin
    px_nxt = '0;
    py_nxt = '0;
    if (!start) begin
      if (px == PX_MAX) begin
        px_nxt = '0;
        py_nxt = py + PW'(1);
      end else begin
        px_nxt = px + PW'(1);
        py_nxt = py;
      end
    end
  end

  // Pixel registers: coordinates are formed 9 bits wide and truncated to the screen widths.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px     <= '0;
      py     <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      wren   <= 1'b0;
    end else if (start) begin
      px     <= px_nxt;
      py     <= py_nxt;
      x      <= SCR_X_W'(base_x + 9'(px_nxt));
      y      <= SCR_Y_W'(base_y + 9'(py_nxt));
      colour <= cell_colour;
      wren   <= 1'b1;
    end else if (wren) begin
      if (last) begin
        wren <= 1'b0;
      end else begin
        px <= px_nxt;
        py <= py_nxt;
        x  <= SCR_X_W'(base_x + 9'(px_nxt));
        y  <= SCR_Y_W'(base_y + 9'(py_nxt));
      end
    end
  end

endmodule

// File: rtl/board_renderer.sv
// Renders the whole Tetris board RAM to the VGA adapter, one CELL_PX square per cell.
// Latency: first pixel 3 cycles after go; 2+CELL_PX^2 cycles per cell; done pulses after last cell.
// Backpressure: none toward the VGA adapter; go is ignored while busy, controller waits for done.
module board_renderer
  import tetris_pkg::*;
#(
  parameter int CELL_PX  = 5,
  parameter int ORIGIN_X = 55,
  parameter int ORIGIN_Y = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                go,
  input  logic [COLOUR_W-1:0] ram_q,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [SCR_X_W-1:0]  X,
  output logic [SCR_Y_W-1:0]  Y,
  output logic [COLOUR_W-1:0] colour,
  output logic                wren,
  output logic                busy,
  output logic                done
);

  // Refuse to elaborate a board that spills off the screen or out of the RAM.
  if ((ORIGIN_X + BOARD_W * CELL_PX > SCR_W) ||
      (ORIGIN_Y + BOARD_H * CELL_PX > SCR_H) ||
      (CELLS > (1 << RAM_AW))) begin : g_bad_geometry
    $error("board_renderer: board geometry does not fit the screen or the board RAM");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LATCH,
    ST_PAINT,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [RAM_AW-1:0] row;
  logic [RAM_AW-1:0] col;
  logic [8:0]        base_x;
  logic [8:0]        base_y;
  logic              paint_start;
  logic              paint_last;
  logic              cell_is_last;

  assign cell_is_last = (row == RAM_AW'(BOARD_H - 1)) && (col == RAM_AW'(BOARD_W - 1));

  // RAM data is valid during LATCH, so the painter captures it on the LATCH exit edge.
  assign paint_start = (state == ST_LATCH);

  assign base_x = 9'(ORIGIN_X + int'(col) * CELL_PX);
  assign base_y = 9'(ORIGIN_Y + int'(row) * CELL_PX);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: address, wait one RAM cycle, paint, repeat until the last cell.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (go) state_nxt = ST_ADDR;
      ST_ADDR:  state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_PAINT;
      ST_PAINT: begin
        if (paint_last) begin
          state_nxt = cell_is_last ? ST_DONE : ST_ADDR;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Cell walk, RAM address and status flags; flags are registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row      <= '0;
      col      <= '0;
      ram_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      done <= (state_nxt == ST_DONE);
      if ((state == ST_IDLE) && go) begin
        row      <= '0;
        col      <= '0;
        ram_addr <= '0;
      end else if ((state == ST_PAINT) && paint_last && !cell_is_last) begin
        // Last cell keeps its address so ram_addr stays in range through DONE.
        ram_addr <= ram_addr + RAM_AW'(1);
        if (col == RAM_AW'(BOARD_W - 1)) begin
          col <= '0;
          row <= row + RAM_AW'(1);
        end else begin
          col <= col + RAM_AW'(1);
        end
      end
    end
  end

  cell_painter #(
    .CELL_PX (CELL_PX)
  ) u_cell_painter (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (paint_start),
    .base_x      (base_x),
    .base_y      (base_y),
    .cell_colour (ram_q),
    .x           (X),
    .y           (Y),
    .colour      (colour),
    .wren        (wren),
    .last        (paint_last)
  );

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer with a one-cycle-latency board RAM model.
// Latency: checks go-to-first-pixel, per-frame length and done/busy timing.
// Backpressure: n/a; pixels are collected every cycle wren is high.
module tb_board_renderer;
  import tetris_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic [5:0] ram_q;
  logic [7:0] ram_addr;
  logic [7:0] X;
  logic [6:0] Y;
  logic [5:0] colour;
  logic       wren;
  logic       busy;
  logic       done;

  logic [5:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  // Per-frame observations.
  int          n_wren, first_wren, last_wren, done_cyc, busy_after, busy_k1, addr_k1;
  int          max_addr, bad_px, bad_cov, busy_gap;
  logic [20:0] pix_q [$];
  int          scr_cnt [160][120];

  always #5 clk = ~clk;

  // Board RAM: address registered, data one cycle later.
  always @(posedge clk) ram_q <= mem[ram_addr];

  board_renderer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .go       (go),
    .ram_q    (ram_q),
    .ram_addr (ram_addr),
    .X        (X),
    .Y        (Y),
    .colour   (colour),
    .wren     (wren),
    .busy     (busy),
    .done     (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // Colour the screen pixel should carry, from the board contents.
  function automatic logic [5:0] exp_col(input int xi, input int yi);
    return mem[((yi - 10) / 5) * 10 + (xi - 55) / 5];
  endfunction

  // Caller sets go=1 just after a falling edge; the following rising edge is E0.
  // Cycle k is the interval between E(k-1) and E(k), sampled at its falling edge.
  task automatic run_frame(input bit hold, input bit pulse);
    n_wren = 0; first_wren = 0; last_wren = 0; done_cyc = 0; busy_after = -1;
    busy_k1 = -1; addr_k1 = -1; max_addr = 0; bad_px = 0; bad_cov = 0; busy_gap = 0;
    pix_q.delete();
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++) scr_cnt[i][j] = 0;
    for (int k = 1; k <= 6000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        busy_k1 = int'(busy);
        addr_k1 = int'(ram_addr);
        if (!hold) go = 1'b0;
      end
      if (pulse) go = (k == 100) || (k == 2500) || (k == 2501);
      if (done_cyc != 0) begin
        busy_after = int'(busy);
        break;
      end
      if (done) done_cyc = k;
      if (!busy) busy_gap++;
      if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
      if (wren) begin
        int xi, yi;
        xi = int'(X);
        yi = int'(Y);
        n_wren++;
        if (first_wren == 0) first_wren = k;
        last_wren = k;
        pix_q.push_back({X, Y, colour});
        if (xi < 55 || xi > 104 || yi < 10 || yi > 109) begin
          bad_px++;
        end else begin
          scr_cnt[xi][yi]++;
          if (colour !== exp_col(xi, yi)) bad_px++;
        end
      end
    end
    for (int i = 55; i <= 104; i++)
      for (int j = 10; j <= 109; j++)
        if (scr_cnt[i][j] != 1) bad_cov++;
  endtask

  function automatic logic [31:0] pix_at(input int idx);
    if (idx < pix_q.size()) return 32'(pix_q[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 6'h00;

    // Reset state.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst X", 32'(X), 0);
    check_eq("rst Y", 32'(Y), 0);
    check_eq("rst colour", 32'(colour), 0);
    check_eq("rst wren", 32'(wren), 0);
    check_eq("rst busy", 32'(busy), 0);
    check_eq("rst done", 32'(done), 0);
    check_eq("rst ram_addr", 32'(ram_addr), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Frame A: empty board, timing and full coverage with colour 0.
    go = 1'b1;
    run_frame(0, 0);
    check_eq("A wren count", 32'(n_wren), 5000);
    check_eq("A bad pixels", 32'(bad_px), 0);
    check_eq("A coverage", 32'(bad_cov), 0);
    check_eq("A busy cycle1", 32'(busy_k1), 1);
    check_eq("A addr cycle1", 32'(addr_k1), 0);
    check_eq("A first wren cycle", 32'(first_wren), 3);
    check_eq("A last wren cycle", 32'(last_wren), 5400);
    check_eq("A done cycle", 32'(done_cyc), 5401);
    check_eq("A busy after done", 32'(busy_after), 0);
    check_eq("A busy gaps", 32'(busy_gap), 0);
    check_eq("A max ram_addr", 32'(max_addr), 199);

    // Frame B: three marked cells, pixel order and placement.
    mem[0] = 6'h3F; mem[34] = 6'h30; mem[199] = 6'h0C;
    @(negedge clk);
    go = 1'b1;
    run_frame(0, 0);
    check_eq("B wren count", 32'(n_wren), 5000);
    check_eq("B pix0", pix_at(0), 32'({8'd55, 7'd10, 6'h3F}));
    check_eq("B pix1", pix_at(1), 32'({8'd56, 7'd10, 6'h3F}));
    check_eq("B pix5", pix_at(5), 32'({8'd55, 7'd11, 6'h3F}));
    check_eq("B pix24", pix_at(24), 32'({8'd59, 7'd14, 6'h3F}));
    check_eq("B pix25 neighbour", pix_at(25), 32'({8'd60, 7'd10, 6'h00}));
    check_eq("B cell33 last", pix_at(849), 32'({8'd74, 7'd29, 6'h00}));
    check_eq("B cell34 first", pix_at(850), 32'({8'd75, 7'd25, 6'h30}));
    check_eq("B cell34 last", pix_at(874), 32'({8'd79, 7'd29, 6'h30}));
    check_eq("B cell35 first", pix_at(875), 32'({8'd80, 7'd25, 6'h00}));
    check_eq("B cell199 first", pix_at(4975), 32'({8'd100, 7'd105, 6'h0C}));
    check_eq("B cell199 last", pix_at(4999), 32'({8'd104, 7'd109, 6'h0C}));
    check_eq("B bad pixels", 32'(bad_px), 0);
    check_eq("B coverage", 32'(bad_cov), 0);
    check_eq("B done after last wren", 32'(done_cyc - last_wren), 1);
    check_eq("B max ram_addr", 32'(max_addr), 199);

    // Frame C: distinct colour per cell, go held high across two frames.
    for (int i = 0; i < 200; i++) mem[i] = 6'(i);
    @(negedge clk);
    go = 1'b1;
    run_frame(1, 0);
    check_eq("C1 wren count", 32'(n_wren), 5000);
    check_eq("C1 bad pixels", 32'(bad_px), 0);
    check_eq("C1 coverage", 32'(bad_cov), 0);
    check_eq("C1 done cycle", 32'(done_cyc), 5401);
    check_eq("C1 busy after done", 32'(busy_after), 0);
    run_frame(0, 0);
    check_eq("C2 busy restart", 32'(busy_k1), 1);
    check_eq("C2 addr restart", 32'(addr_k1), 0);
    check_eq("C2 wren count", 32'(n_wren), 5000);
    check_eq("C2 bad pixels", 32'(bad_px), 0);
    check_eq("C2 done cycle", 32'(done_cyc), 5401);

    // Frame D: go pulses mid-frame must not restart the walk.
    @(negedge clk);
    go = 1'b1;
    run_frame(0, 1);
    check_eq("D wren count", 32'(n_wren), 5000);
    check_eq("D bad pixels", 32'(bad_px), 0);
    check_eq("D done cycle", 32'(done_cyc), 5401);

    // Reset during the paint of cell 50 (its pixels occupy cycles 1353..1377).
    for (int i = 0; i < 200; i++) mem[i] = 6'h15;
    mem[0] = 6'h3F;
    @(negedge clk);
    go = 1'b1;
    for (int k = 1; k <= 1360; k++) begin
      @(negedge clk);
      if (k == 1) go = 1'b0;
    end
    check_eq("R wren before reset", 32'(wren), 1);
    check_eq("R addr before reset", 32'(ram_addr), 50);
    reset_n = 1'b0;
    #1;
    check_eq("R wren async", 32'(wren), 0);
    check_eq("R X async", 32'(X), 0);
    check_eq("R Y async", 32'(Y), 0);
    check_eq("R colour async", 32'(colour), 0);
    check_eq("R busy async", 32'(busy), 0);
    check_eq("R ram_addr async", 32'(ram_addr), 0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (wren) n++;
    end
    check_eq("R wren in reset", 32'(n), 0);
    reset_n = 1'b1;
    @(negedge clk);
    go = 1'b1;
    run_frame(0, 0);
    check_eq("R restart addr", 32'(addr_k1), 0);
    check_eq("R restart pix0", pix_at(0), 32'({8'd55, 7'd10, 6'h3F}));
    check_eq("R wren count", 32'(n_wren), 5000);
    check_eq("R bad pixels", 32'(bad_px), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit in case the bench itself stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
